// File: rtl/wrf_pkg.sv
// Shared word classes and sink FSM states for the
// fabric sink buffer.
package wrf_pkg;

  localparam logic [1:0] ADR_DATA   = 2'b00;
  localparam logic [1:0] ADR_OOB    = 2'b01;
  localparam logic [1:0] ADR_STATUS = 2'b10;
  localparam logic [1:0] ADR_USER   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } wrf_state_t;

endpackage

// File: rtl/wrf_buf_ram.sv
// Frame storage: one write port, one async read port and
// a separate port that sets the last-word flag.
module wrf_buf_ram
  import wrf_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int W     = 20
) (
  input  logic          clk_sys,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_adr,
  input  logic [W-1:0]  wr_dat,
  input  logic          last_en,
  input  logic [AW-1:0] last_adr,
  input  logic [AW-1:0] rd_adr,
  output logic [W-1:0]  rd_dat,
  output logic          rd_last
);

  logic [W-1:0]     mem [DEPTH];
  logic [DEPTH-1:0] last_q;

  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[wr_adr] <= wr_dat;
  end

  // A fresh write clears the flag; marking the frame end wins.
  always_ff @(posedge clk_sys) begin
    if (wr_en)   last_q[wr_adr]   <= 1'b0;
    if (last_en) last_q[last_adr] <= 1'b1;
  end

  assign rd_dat  = mem[rd_adr];
  assign rd_last = last_q[rd_adr];

endmodule

// File: rtl/wrf_sink_buffer.sv
// Store-and-forward buffer between a pipelined Wishbone
// sink and a valid/ready stream; oversize frames are dropped.
module wrf_sink_buffer
  import wrf_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int DAT_W = 16
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             snk_cyc,
  input  logic             snk_stb,
  input  logic             snk_we,
  input  logic [1:0]       snk_adr,
  input  logic [DAT_W-1:0] snk_dat,
  input  logic [1:0]       snk_sel,
  output logic             snk_ack,
  output logic             snk_err,
  output logic             snk_stall,
  output logic             snk_rty,
  output logic             src_valid,
  input  logic             src_ready,
  output logic [DAT_W-1:0] src_dat,
  output logic [1:0]       src_adr,
  output logic [1:0]       src_sel,
  output logic             src_last,
  output logic [15:0]      drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DAT_W + 4;
  localparam logic [PW-1:0] LIM = PW'(DEPTH - 1);

  wrf_state_t    state;
  logic [PW-1:0] wr_ptr, cm_ptr, rd_ptr;
  logic [PW-1:0] wr_nxt, cm_nxt, rd_nxt;
  logic          accept, store, pop, fall;
  logic          commit, ovf, nxt_drop, stall_nxt;
  logic [EW-1:0] rd_ent;

  assign snk_rty = 1'b0;

  assign accept = snk_cyc & snk_stb & ~snk_stall;
  assign fall   = (state != ST_IDLE) & ~snk_cyc;
  assign store  = accept & snk_we & (state != ST_DROP);
  assign commit = fall & (state == ST_RECV)
                & (wr_ptr != cm_ptr);

  assign src_valid = rd_ptr != cm_ptr;
  assign pop       = src_valid & src_ready;

  always_comb begin
    wr_nxt = wr_ptr + PW'(store);
    if (fall && state == ST_DROP) wr_nxt = cm_ptr;
    cm_nxt = commit ? wr_ptr : cm_ptr;
    rd_nxt = rd_ptr + PW'(pop);
  end

  // Overflow is judged on the in-flight frame alone.
  assign ovf       = store & ((wr_nxt - cm_ptr) == LIM);
  assign nxt_drop  = ovf | ((state == ST_DROP) & snk_cyc);
  assign stall_nxt = ~nxt_drop & ((wr_nxt - rd_nxt) >= LIM);

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      cm_ptr    <= '0;
      rd_ptr    <= '0;
      snk_ack   <= 1'b0;
      snk_err   <= 1'b0;
      snk_stall <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      wr_ptr    <= wr_nxt;
      cm_ptr    <= cm_nxt;
      rd_ptr    <= rd_nxt;
      snk_ack   <= accept & (state != ST_DROP);
      snk_err   <= accept & (state == ST_DROP);
      snk_stall <= stall_nxt;
      unique case (state)
        ST_IDLE: begin
          if (snk_cyc)
            state <= ovf ? ST_DROP : ST_RECV;
        end
        ST_RECV: begin
          if (!snk_cyc)  state <= ST_IDLE;
          else if (ovf)  state <= ST_DROP;
        end
        ST_DROP: begin
          if (!snk_cyc) begin
            state <= ST_IDLE;
            if (drop_cnt != 16'hFFFF)
              drop_cnt <= drop_cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  wrf_buf_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (EW)
  ) u_ram (
    .clk_sys  (clk_sys),
    .wr_en    (store),
    .wr_adr   (wr_ptr[AW-1:0]),
    .wr_dat   ({snk_sel, snk_adr, snk_dat}),
    .last_en  (commit),
    .last_adr (wr_ptr[AW-1:0] - AW'(1)),
    .rd_adr   (rd_ptr[AW-1:0]),
    .rd_dat   (rd_ent),
    .rd_last  (src_last)
  );

  assign {src_sel, src_adr, src_dat} = rd_ent;

endmodule

// File: tb/tb_wrf_sink_buffer.sv
// Randomised bench for wrf_sink_buffer against a
// frame-level queue model.
module tb_wrf_sink_buffer;

  localparam int DEPTH = 64;
  localparam int DAT_W = 16;

  logic             clk_sys = 1'b0;
  logic             rst;
  logic             snk_cyc, snk_stb, snk_we;
  logic [1:0]       snk_adr, snk_sel;
  logic [DAT_W-1:0] snk_dat;
  logic             snk_ack, snk_err, snk_stall, snk_rty;
  logic             src_valid, src_ready, src_last;
  logic [DAT_W-1:0] src_dat;
  logic [1:0]       src_adr, src_sel;
  logic [15:0]      drop_cnt;

  always #5 clk_sys = ~clk_sys;

  wrf_sink_buffer #(.DEPTH(DEPTH), .DAT_W(DAT_W)) dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .snk_cyc   (snk_cyc),
    .snk_stb   (snk_stb),
    .snk_we    (snk_we),
    .snk_adr   (snk_adr),
    .snk_dat   (snk_dat),
    .snk_sel   (snk_sel),
    .snk_ack   (snk_ack),
    .snk_err   (snk_err),
    .snk_stall (snk_stall),
    .snk_rty   (snk_rty),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_dat   (src_dat),
    .src_adr   (src_adr),
    .src_sel   (src_sel),
    .src_last  (src_last),
    .drop_cnt  (drop_cnt)
  );

  typedef struct packed {
    logic             last;
    logic [1:0]       sel;
    logic [1:0]       adr;
    logic [DAT_W-1:0] dat;
  } ent_t;

  ent_t pend[$];
  ent_t out_q[$];
  bit   dropping;
  bit   rdy_rand;
  int   exp_drops;
  int   total, bad;
  int   n_ack, n_err, popped;

  function automatic void model_clear();
    pend.delete();
    out_q.delete();
    dropping  = 0;
    exp_drops = 0;
  endfunction

  function automatic logic [1:0] model_accept(
    logic we, logic [1:0] adr, logic [DAT_W-1:0] dat,
    logic [1:0] sel);
    ent_t e;
    if (dropping) return 2'b01;
    if (we) begin
      e.last = 1'b0; e.sel = sel; e.adr = adr; e.dat = dat;
      pend.push_back(e);
      if (pend.size() == DEPTH - 1) dropping = 1;
    end
    return 2'b10;
  endfunction

  function automatic void model_fall();
    ent_t e;
    if (dropping) begin
      if (exp_drops < 65535) exp_drops++;
      pend.delete();
      dropping = 0;
    end else if (pend.size() > 0) begin
      e = pend.pop_back();
      e.last = 1'b1;
      pend.push_back(e);
      foreach (pend[i]) out_q.push_back(pend[i]);
      pend.delete();
    end
  endfunction

  // Every word leaving the stream must be the oldest committed one.
  always @(negedge clk_sys) begin
    ent_t got, exp;
    if (!rst && src_valid) begin
      got = {src_last, src_sel, src_adr, src_dat};
      if (out_q.size() == 0) begin
        total++; bad++;
        $display("FAIL uncommitted_output got=%h exp=none", got);
      end else if (src_ready) begin
        exp = out_q.pop_front();
        total++; popped++;
        if (got !== exp) begin
          bad++;
          $display("FAIL src_word got=%h exp=%h", got, exp);
        end
      end
    end
  end

  always @(posedge clk_sys) begin
    #1;
    if (rdy_rand) src_ready = 1'($urandom_range(0, 1));
  end

  task automatic put_word(input logic we, input logic [1:0] adr,
                          input logic [DAT_W-1:0] dat,
                          input logic [1:0] sel);
    int w;
    logic [1:0] exp;
    w = 0;
    snk_stb = 1; snk_we = we; snk_adr = adr;
    snk_dat = dat; snk_sel = sel;
    while (snk_stall && w < 300) begin
      @(posedge clk_sys); #1; w++;
    end
    if (snk_stall) begin
      total++; bad++;
      $display("FAIL stall_timeout got=stalled exp=accept");
      snk_stb = 0;
      return;
    end
    @(posedge clk_sys);
    exp = model_accept(we, adr, dat, sel);
    #1;
    snk_stb = 0;
    total++;
    if ({snk_ack, snk_err} !== exp) begin
      bad++;
      $display("FAIL ack_err got=%b exp=%b", {snk_ack, snk_err}, exp);
    end
    if (exp == 2'b01) n_err++; else n_ack++;
  endtask

  task automatic rnd_word(input logic we);
    put_word(we, 2'($urandom_range(0, 3)),
             DAT_W'($urandom), 2'($urandom_range(0, 3)));
  endtask

  task automatic frame_end();
    snk_cyc = 0; snk_stb = 0;
    @(posedge clk_sys);
    model_fall();
    #1;
  endtask

  task automatic send_frame(input int n);
    snk_cyc = 1;
    for (int i = 0; i < n; i++) rnd_word(1'b1);
    frame_end();
  endtask

  task automatic drain();
    int w;
    rdy_rand = 0; src_ready = 1; w = 0;
    while (out_q.size() > 0 && w < 3000) begin
      @(posedge clk_sys); w++;
    end
    #1;
    total++;
    if (out_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout got=%0d exp=0 left", out_q.size());
    end
    total++;
    if (src_valid !== 1'b0) begin
      bad++;
      $display("FAIL drained_valid got=%b exp=0", src_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1; snk_cyc = 0; snk_stb = 0; snk_we = 0;
    snk_adr = 0; snk_dat = 0; snk_sel = 0;
    src_ready = 0; rdy_rand = 0;
    repeat (3) @(posedge clk_sys);
    #1; rst = 0; model_clear();
    total++;
    if ({src_valid, snk_ack, snk_err, snk_stall, snk_rty} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=00000",
               {src_valid, snk_ack, snk_err, snk_stall, snk_rty});
    end
    total++;
    if (drop_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_drop got=%0d exp=0", drop_cnt);
    end
  endtask

  task automatic test_five_word();
    src_ready = 1; n_ack = 0;
    snk_cyc = 1;
    for (int i = 0; i < 5; i++) rnd_word(1'b1);
    total++;
    if (n_ack != 5) begin
      bad++; $display("FAIL five_acks got=%0d exp=5", n_ack);
    end
    total++;
    if (src_valid !== 1'b0) begin
      bad++; $display("FAIL five_early_valid got=%b exp=0", src_valid);
    end
    frame_end();
    total++;
    if (src_valid !== 1'b1) begin
      bad++; $display("FAIL five_valid got=%b exp=1", src_valid);
    end
    drain();
  endtask

  task automatic test_no_stb();
    src_ready = 1;
    snk_cyc = 1;
    repeat (3) @(posedge clk_sys);
    #1;
    frame_end();
    repeat (3) @(posedge clk_sys);
    #1;
    total++;
    if ({src_valid, drop_cnt} !== {1'b0, 16'd0}) begin
      bad++;
      $display("FAIL no_stb got=%b/%0d exp=0/0", src_valid, drop_cnt);
    end
  endtask

  task automatic test_overflow();
    src_ready = 0; n_err = 0;
    send_frame(100);
    total++;
    if (n_err != 100 - (DEPTH - 1)) begin
      bad++;
      $display("FAIL ovf_errs got=%0d exp=%0d", n_err, 100 - (DEPTH - 1));
    end
    total++;
    if (drop_cnt !== 16'd1) begin
      bad++; $display("FAIL ovf_drop got=%0d exp=1", drop_cnt);
    end
    repeat (2) @(posedge clk_sys);
    #1;
    total++;
    if (src_valid !== 1'b0) begin
      bad++; $display("FAIL ovf_valid got=%b exp=0", src_valid);
    end
  endtask

  task automatic test_back_to_back();
    src_ready = 0; popped = 0;
    send_frame(3);
    send_frame(3);
    repeat (3) @(posedge clk_sys);
    #1;
    total++;
    if (src_valid !== 1'b1) begin
      bad++; $display("FAIL b2b_held got=%b exp=1", src_valid);
    end
    drain();
    total++;
    if (popped != 6) begin
      bad++; $display("FAIL b2b_count got=%0d exp=6", popped);
    end
  endtask

  task automatic test_rst_mid();
    src_ready = 0;
    snk_cyc = 1;
    rnd_word(1'b1);
    rnd_word(1'b1);
    rst = 1; snk_cyc = 0;
    @(posedge clk_sys);
    #1; rst = 0; model_clear();
    total++;
    if ({src_valid, drop_cnt} !== {1'b0, 16'd0}) begin
      bad++;
      $display("FAIL rst_mid got=%b/%0d exp=0/0", src_valid, drop_cnt);
    end
    src_ready = 1; popped = 0;
    send_frame(2);
    drain();
    total++;
    if (popped != 2) begin
      bad++; $display("FAIL rst_next got=%0d exp=2", popped);
    end
  endtask

  task automatic test_full_stall();
    logic [DAT_W-1:0] d;
    src_ready = 0; popped = 0;
    send_frame(10);
    snk_cyc = 1;
    for (int i = 0; i < DEPTH - 11; i++) rnd_word(1'b1);
    total++;
    if (snk_stall !== 1'b1) begin
      bad++; $display("FAIL full_stall got=%b exp=1", snk_stall);
    end
    d = DAT_W'($urandom);
    snk_stb = 1; snk_we = 1; snk_adr = 2'b11;
    snk_dat = d; snk_sel = 2'b01;
    repeat (3) begin
      @(posedge clk_sys); #1;
      total++;
      if (snk_ack !== 1'b0) begin
        bad++; $display("FAIL full_no_ack got=%b exp=0", snk_ack);
      end
    end
    src_ready = 1;
    @(posedge clk_sys);
    #1; src_ready = 0;
    total++;
    if (snk_stall !== 1'b0) begin
      bad++; $display("FAIL stall_fall got=%b exp=0", snk_stall);
    end
    put_word(1'b1, 2'b11, d, 2'b01);
    total++;
    if (snk_stall !== 1'b1) begin
      bad++; $display("FAIL stall_rise got=%b exp=1", snk_stall);
    end
    frame_end();
    drain();
    total++;
    if (popped != DEPTH) begin
      bad++; $display("FAIL full_count got=%0d exp=%0d", popped, DEPTH);
    end
  endtask

  task automatic test_random();
    int len;
    rdy_rand = 1;
    for (int f = 0; f < 12; f++) begin
      len = $urandom_range(0, 20);
      snk_cyc = 1;
      for (int i = 0; i < len; i++)
        rnd_word($urandom_range(0, 7) != 0);
      frame_end();
      repeat ($urandom_range(0, 2)) @(posedge clk_sys);
      #1;
    end
    drain();
    total++;
    if (drop_cnt !== 16'(exp_drops)) begin
      bad++;
      $display("FAIL rand_drop got=%0d exp=%0d", drop_cnt, exp_drops);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    n_ack = 0; n_err = 0; popped = 0;
    test_reset();
    test_five_word();
    test_no_stb();
    test_overflow();
    test_back_to_back();
    test_rst_mid();
    test_full_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wrf_sink_buffer.md
WRF_SINK_BUFFER -- requirements
Module: wrf_sink_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 64, buffer entries (power of two, >=4).
REQ-002 SHALL have parameter DAT_W, default 16, fabric data width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk_sys  in  1  system clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 snk_cyc/snk_stb/snk_we  in  1 each  pipelined-Wishbone fabric sink; cyc brackets one frame.
REQ-007 snk_adr  in  2  word class (00 data, 01 OOB, 10 status, 11 user).
REQ-008 snk_dat  in  DAT_W  word payload; snk_sel  in  2  byte-valid mask.
REQ-009 snk_ack/snk_err/snk_stall/snk_rty  out  1 each  sink responses.
REQ-010 src_valid  out  1; src_ready  in  1  valid/ready output stream.
REQ-011 src_dat  out  DAT_W; src_adr  out  2; src_sel  out  2; src_last  out  1 (final word of frame).
REQ-012 drop_cnt  out  16  count of dropped frames.

Function
REQ-013 SHALL store-and-forward: no word of a frame appears on src_* until the frame is committed.
REQ-014 Accept = snk_cyc & snk_stb & !snk_stall; snk_ack or snk_err SHALL assert exactly one cycle after each accept, never both.
REQ-015 snk_stall SHALL be registered, asserting when entries used (committed plus in-flight) >= DEPTH-1.
REQ-016 Accepted word with snk_we=0 SHALL be acked and not stored.
REQ-017 Stored entry SHALL be {last, sel, adr, dat}; write pointer advances by one per stored word.
REQ-018 On snk_cyc falling edge with >=1 stored word: set last bit of entry wr_ptr-1 and commit (committed pointer := wr_ptr) in that cycle.
REQ-019 On snk_cyc falling edge with zero stored words: no commit, no drop count.
REQ-020 Overflow: when in-flight frame occupies DEPTH-1 entries, frame SHALL enter DROP state; stall SHALL deassert, further words acked with snk_err and discarded.
REQ-021 On cyc fall in DROP: wr_ptr := committed pointer, drop_cnt += 1 (saturating at 0xFFFF), return to IDLE.
REQ-022 FSM states: IDLE (cyc low), RECV (storing), DROP (discarding); IDLE->RECV on cyc rise, RECV->DROP on overflow, RECV/DROP->IDLE on cyc fall.
REQ-023 src_valid SHALL be high when rd_ptr != committed pointer; word pops when src_valid & src_ready; src_* stable while valid & !ready.
REQ-024 Pointers SHALL be log2(DEPTH)+1 bits, wrap modulo 2*DEPTH; full/empty by MSB compare.
REQ-025 Commit and pop in same cycle SHALL both take effect; freed entry counts toward stall next cycle.
REQ-026 snk_rty SHALL be constant 0.

Reset
REQ-027 rst SHALL clear all pointers, FSM to IDLE, drop_cnt to 0, snk_ack/err/stall to 0, src_valid to 0; entry storage not cleared.
REQ-028 rst mid-frame SHALL discard the frame without counting it as a drop.

Structure
REQ-029 Word-class constants (ADR_DATA, ADR_OOB, ADR_STATUS, ADR_USER) and FSM state enum SHALL live in shared package wrf_pkg.
REQ-030 Storage SHALL be sub-module wrf_buf_ram (1 write, 1 read, plus last-bit write port).

Verification
REQ-031 5-word frame, src_ready=1 -> 5 acks, src_valid first high 1 cycle after cyc fall, src_last on word 5 only.
REQ-032 DEPTH=64, 100-word frame -> words 64..100 get snk_err, nothing on src, drop_cnt=1.
REQ-033 Two back-to-back 3-word frames, src_ready=0 then 1 -> 6 words out in order, src_last on words 3 and 6.
REQ-034 cyc pulse with no stb -> no output, drop_cnt=0.
REQ-035 rst asserted after word 2 of 4-word frame -> src_valid=0, drop_cnt=0; next 2-word frame delivered intact.
REQ-036 Full buffer with stall high, pop one word with src_ready -> snk_stall falls next cycle and one word accepted.
